// File: rtl/data_memory_ws.sv
// data_memory_ws: byte-stored word memory with configurable wait states and out-of-range flagging
module data_memory_ws #(
   parameter int          DEPTH_BYTES = 256,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] dataToWrite,
   output logic [31:0] result,
   output logic        ready,
   output logic        addr_err
);
   localparam int WA = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES / 4) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [7:0] mem [0:DEPTH_BYTES-1];
   logic [31:0] off, wdata_q, word;
   logic [WA-1:0] wa_q;
   logic [3:0] cnt;
   logic req, in_rng, op_w_q, in_rng_q;
   assign req = mem_r_en | mem_w_en;
   assign off = address - BASE_ADDR;
   assign in_rng = (address >= BASE_ADDR) && (off <= 32'(DEPTH_BYTES - 4));
   assign word = {mem[{wa_q, 2'd3}], mem[{wa_q, 2'd2}], mem[{wa_q, 2'd1}], mem[{wa_q, 2'd0}]};
   // state register; latch the request on acceptance and count down the wait states
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         op_w_q <= 1'b0;
         in_rng_q <= 1'b0;
         wa_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            cnt <= 4'(WAIT_CYCLES);
            op_w_q <= mem_w_en;
            in_rng_q <= in_rng;
            wa_q <= off[WA+1:2];
            wdata_q <= dataToWrite;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
      end
   end
   // storage is never reset; an in-range write commits on the edge leaving DONE
   always_ff @(posedge clk) begin
      if (state == DONE && op_w_q && in_rng_q) begin
         mem[{wa_q, 2'd0}] <= wdata_q[7:0];
         mem[{wa_q, 2'd1}] <= wdata_q[15:8];
         mem[{wa_q, 2'd2}] <= wdata_q[23:16];
         mem[{wa_q, 2'd3}] <= wdata_q[31:24];
      end
   end
   // next-state and output decode; ready is only combinational from the request in IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req ? ((WAIT_CYCLES == 0) ? DONE : BUSY) : IDLE;
         BUSY:    state_nx = (cnt == 4'd1) ? DONE : BUSY;
         default: state_nx = IDLE;
      endcase
      ready = (state == IDLE) ? ~req : (state == DONE);
      addr_err = (state == DONE) && !in_rng_q;
      result = (state == DONE && !op_w_q && in_rng_q) ? word : '0;
   end
endmodule

// File: doc/data_memory_ws.md
# data_memory_ws

Word-organised, byte-stored data memory with a configurable base address, depth and access latency. It sits in the MEM stage of the ARM pipeline. When an access takes more than one cycle, it stalls the pipeline through a `ready` handshake. It also flags addresses outside its window instead of aliasing them.

## Interface
- `DEPTH_BYTES`, 256: storage size in bytes; a multiple of 4, at least 4.
- `BASE_ADDR`, 1024: byte address that maps to storage byte 0; a multiple of 4.
- `WAIT_CYCLES`, 1: number of extra cycles per access, 0..15.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `mem_r_en` input 1: read request.
- `mem_w_en` input 1: write request; takes priority over `mem_r_en` when both are high.
- `address` input 32: byte address; `address[1:0]` is ignored.
- `dataToWrite` input 32: write data.
- `result` output 32: read data; valid only while `ready`=1 in DONE for a read.
- `ready` output 1: low means stall the pipeline; the requester holds its inputs.
- `addr_err` output 1: high during DONE when the latched address is out of range.

## Operation
- Storage: `reg [7:0] mem[0:DEPTH_BYTES-1]`.
  - Not reset and not initialised by reset.
- Offset: `off = (address - BASE_ADDR)` computed in 32 bits, then `off[1:0]` forced to 0.
- In range means `address >= BASE_ADDR` and `address - BASE_ADDR <= DEPTH_BYTES-4`.
  - The comparison is done on the unforced difference.
  - There is no wrap-around or aliasing.
- Byte order is little-endian:
  - `mem[off]` = `data[7:0]`, `mem[off+1]` = `[15:8]`, `mem[off+2]` = `[23:16]`, `mem[off+3]` = `[31:24]`.
  - A read returns `{mem[off+3],mem[off+2],mem[off+1],mem[off]}`.
- `req` = `mem_r_en | mem_w_en`.
- On acceptance the block latches op, offset, in-range flag and write data.
  - After acceptance, input changes are ignored until the block returns to IDLE.
- FSM states are IDLE, BUSY and DONE.
  - IDLE:
    - `ready` = `~req` (combinational).
    - If `req`: latch the request, load the counter with `WAIT_CYCLES`, then go to BUSY (or to DONE if `WAIT_CYCLES`=0).
  - BUSY:
    - `ready`=0.
    - The counter decrements each cycle; at counter==1 go to DONE.
    - BUSY lasts exactly `WAIT_CYCLES` cycles.
  - DONE:
    - `ready`=1.
    - Read, in range: `result` = memory word; `addr_err`=0.
    - Out of range: `result`=0, `addr_err`=1, no write.
    - Write, in range: all 4 bytes are committed at the rising edge that leaves DONE; `result`=0.
    - Next state is always IDLE.
- Outside DONE: `result`=0 and `addr_err`=0.
- A request held high across the DONE→IDLE edge is accepted again in IDLE. The requester must advance on the `ready` edge.
- A read issued right after a write to the same word returns the new data.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, counter=0, latched request cleared.
  - Outputs: `result`=0, `addr_err`=0, `ready`=1 when `req`=0.
- Latency: a request first presented in cycle T sees `ready`=1 and valid `result` in cycle T+1+`WAIT_CYCLES`.
- Throughput: one access per 2+`WAIT_CYCLES` cycles, because IDLE is an acceptance bubble.
- If reset is asserted mid-BUSY or in DONE:
  - The access is abandoned and no memory byte changes.
  - After `rst` is released, the FSM is in IDLE.
- `ready` has a combinational path only from `mem_r_en`/`mem_w_en` in IDLE. `result` and `addr_err` are decoded from registered state.

## Test plan
All scenarios use defaults `BASE_ADDR`=1024, `DEPTH_BYTES`=256, `WAIT_CYCLES`=2 unless stated.

1. Write `dataToWrite`=0xA1B2C3D4 to 1028, then read 1028:
   - `ready` is low for 3 cycles per access.
   - The read gives `result`=0xA1B2C3D4.
   - Byte `mem[4]`=0xD4 and `mem[7]`=0xA1.
2. Read 1031 after the write in scenario 1: `result`=0xA1B2C3D4, because the low address bits are ignored.
3. Out-of-range accesses:
   - Read 1020 and read 1280 each give `addr_err`=1 and `result`=0 in DONE.
   - Write 1280 leaves `mem[252..255]` unchanged.
   - Read 1276 is in range and gives `addr_err`=0.
4. Reset mid-operation:
   - Write 0x11111111 to 1024, then start a write of 0x22222222 to 1024.
   - Pulse `rst` low during BUSY.
   - Expect state IDLE and `ready`=1; a subsequent read of 1024 returns 0x11111111.
5. `WAIT_CYCLES`=0 with back-to-back reads held high:
   - `ready` alternates 0,1,0,1.
   - `result` is valid on every `ready`=1 cycle.
6. `mem_r_en`=`mem_w_en`=1 with data 0x5A5A5A5A at 1032: performed as a write; `result`=0; a following read of 1032 returns 0x5A5A5A5A.
